// File: rtl/ctrl_pipe_reg_pkg.sv
// Shared control-word type for the control pipeline register.
// Holds the NOP constant that reset, flush and input gating load.
package ctrl_pipe_pkg;

    typedef struct packed {
        logic       valid;
        logic [2:0] DMCtrl;
        logic [1:0] RUDataWrSrc;
        logic       RuWr;
        logic       DMWr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        valid:       1'b0,
        DMCtrl:      3'b000,
        RUDataWrSrc: 2'b00,
        RuWr:        1'b0,
        DMWr:        1'b0
    };

    localparam int MAX_DEPTH = 4;

endpackage

// File: rtl/ctrl_pipe_reg_if.sv
// Pipeline-control bundle: hazard controls, incoming control word,
// final-stage control word and the squash counter.
interface ctrl_pipe_reg_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic             valid_in;
    logic [2:0]       DMCtrl_in;
    logic [1:0]       RUDataWrSrc_in;
    logic             RuWr_in;
    logic             DMWr_in;
    logic             valid_out;
    logic [2:0]       DMCtrl_out;
    logic [1:0]       RUDataWrSrc_out;
    logic             RuWr_out;
    logic             DMWr_out;
    logic [CNT_W-1:0] squash_cnt;

    modport master (
        output stall, flush, valid_in, DMCtrl_in, RUDataWrSrc_in, RuWr_in, DMWr_in,
        input  valid_out, DMCtrl_out, RUDataWrSrc_out, RuWr_out, DMWr_out, squash_cnt
    );

    modport slave (
        input  stall, flush, valid_in, DMCtrl_in, RUDataWrSrc_in, RuWr_in, DMWr_in,
        output valid_out, DMCtrl_out, RUDataWrSrc_out, RuWr_out, DMWr_out, squash_cnt
    );
endinterface

// File: rtl/ctrl_pipe_reg_stage.sv
// One control-word register stage; reset and flush both load NOP,
// stall holds the current contents.
module ctrl_stage
    import ctrl_pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  stall,
    input  ctrl_t d,
    output ctrl_t q
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q <= CTRL_NOP;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipe_reg.sv
// DEPTH-stage control pipeline register with stall/flush and a
// saturating count of live words squashed by flushes.
module ctrl_pipe_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int CNT_W = 16
) (
    input logic           clk,
    input logic           rst,
    ctrl_pipe_reg_if.slave bus
);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("ctrl_pipe_reg: DEPTH must be in 1..4");
    end
    if (CNT_W < 3) begin : g_bad_cnt_w
        $error("ctrl_pipe_reg: CNT_W must be at least 3");
    end

    ctrl_t            in_word;
    ctrl_t            stg_d [DEPTH];
    ctrl_t            stg_q [DEPTH];
    logic [2:0]       live_cnt;
    logic [CNT_W-1:0] squash_q;

    // An increment of up to DEPTH may jump past the top; clamp instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-2){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        in_word = CTRL_NOP;
        if (bus.valid_in) begin
            in_word.valid       = 1'b1;
            in_word.DMCtrl      = bus.DMCtrl_in;
            in_word.RUDataWrSrc = bus.RUDataWrSrc_in;
            in_word.RuWr        = bus.RuWr_in;
            in_word.DMWr        = bus.DMWr_in;
        end
    end

    assign stg_d[0] = in_word;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign stg_d[k] = stg_q[k-1];
        end
        ctrl_stage u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (bus.flush),
            .stall (bus.stall),
            .d     (stg_d[k]),
            .q     (stg_q[k])
        );
    end

    always_comb begin
        live_cnt = 3'd0;
        for (int k = 0; k < DEPTH; k++) begin
            live_cnt = live_cnt + {2'b00, stg_q[k].valid};
        end
    end

    // Squash counting happens only on a flush edge that is not also a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            squash_q <= '0;
        end else if (bus.flush) begin
            squash_q <= sat_add(squash_q, live_cnt);
        end
    end

    assign bus.valid_out       = stg_q[DEPTH-1].valid;
    assign bus.DMCtrl_out      = stg_q[DEPTH-1].DMCtrl;
    assign bus.RUDataWrSrc_out = stg_q[DEPTH-1].RUDataWrSrc;
    assign bus.RuWr_out        = stg_q[DEPTH-1].RuWr;
    assign bus.DMWr_out        = stg_q[DEPTH-1].DMWr;
    assign bus.squash_cnt      = squash_q;

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Directed bench for ctrl_pipe_reg at DEPTH=2, DEPTH=3 and DEPTH=4/CNT_W=3.
module tb_ctrl_pipe_reg;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ctrl_pipe_reg_if #(.CNT_W(16)) b2 ();
    ctrl_pipe_reg_if #(.CNT_W(16)) b3 ();
    ctrl_pipe_reg_if #(.CNT_W(3))  b4 ();

    ctrl_pipe_reg #(.DEPTH(2), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    ctrl_pipe_reg #(.DEPTH(3), .CNT_W(16)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
    ctrl_pipe_reg #(.DEPTH(4), .CNT_W(3))  u4 (.clk(clk), .rst(rst), .bus(b4.slave));

    // Word layout {valid, DMCtrl[2:0], RUDataWrSrc[1:0], RuWr, DMWr}
    wire [7:0] o2 = {b2.valid_out, b2.DMCtrl_out, b2.RUDataWrSrc_out, b2.RuWr_out, b2.DMWr_out};
    wire [7:0] o3 = {b3.valid_out, b3.DMCtrl_out, b3.RUDataWrSrc_out, b3.RuWr_out, b3.DMWr_out};
    wire [7:0] o4 = {b4.valid_out, b4.DMCtrl_out, b4.RUDataWrSrc_out, b4.RuWr_out, b4.DMWr_out};

    localparam logic [7:0] W_A  = 8'hA6;
    localparam logic [7:0] W_G  = 8'h7F;
    localparam logic [7:0] W1   = 8'h81;
    localparam logic [7:0] W2   = 8'h9A;
    localparam logic [7:0] W3   = 8'hF7;
    localparam logic [7:0] W_X  = 8'hC3;
    localparam logic [7:0] NOPW = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic [7:0] w);
        b2.valid_in = w[7]; b2.DMCtrl_in = w[6:4]; b2.RUDataWrSrc_in = w[3:2];
        b2.RuWr_in = w[1];  b2.DMWr_in = w[0];
    endtask

    task automatic drive3(input logic [7:0] w);
        b3.valid_in = w[7]; b3.DMCtrl_in = w[6:4]; b3.RUDataWrSrc_in = w[3:2];
        b3.RuWr_in = w[1];  b3.DMWr_in = w[0];
    endtask

    task automatic drive4(input logic [7:0] w);
        b4.valid_in = w[7]; b4.DMCtrl_in = w[6:4]; b4.RUDataWrSrc_in = w[3:2];
        b4.RuWr_in = w[1];  b4.DMWr_in = w[0];
    endtask

    initial begin
        rst = 1'b1;
        b2.stall = 1'b0; b2.flush = 1'b0; drive2(NOPW);
        b3.stall = 1'b0; b3.flush = 1'b0; drive3(NOPW);
        b4.stall = 1'b0; b4.flush = 1'b0; drive4(NOPW);
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_out_d2", o2, NOPW);
        check_eq("rst_out_d3", o3, NOPW);
        check_eq("rst_out_d4", o4, NOPW);
        check_eq("rst_cnt_d2", b2.squash_cnt, 0);
        check_eq("rst_cnt_d3", b3.squash_cnt, 0);
        check_eq("rst_cnt_d4", b4.squash_cnt, 0);

        // DEPTH=2 latency, then a gated non-live word must come out as NOP
        drive2(W_A);
        tick();
        check_eq("d2_lat_e1", o2, NOPW);
        drive2(W_G);
        tick();
        check_eq("d2_lat_e2", o2, W_A);
        drive2(NOPW);
        tick();
        check_eq("d2_gated", o2, NOPW);

        // DEPTH=3 stall with three live words in flight
        drive3(W1); tick();
        drive3(W2); tick();
        drive3(W3); tick();
        check_eq("d3_first", o3, W1);
        b3.stall = 1'b1;
        drive3(W_X);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("d3_stall_out", o3, W1);
            check_eq("d3_stall_cnt", b3.squash_cnt, 0);
        end
        b3.stall = 1'b0;
        drive3(NOPW);
        tick(); check_eq("d3_resume1", o3, W2);
        tick(); check_eq("d3_resume2", o3, W3);
        tick(); check_eq("d3_drain", o3, NOPW);

        // DEPTH=3 flush+stall with two live stages, then a second flush
        drive3(W1); tick();
        drive3(W2); tick();
        check_eq("d3_pre_flush", o3, NOPW);
        b3.flush = 1'b1; b3.stall = 1'b1;
        drive3(W3);
        tick();
        check_eq("d3_flush_out", o3, NOPW);
        check_eq("d3_flush_cnt", b3.squash_cnt, 2);
        b3.stall = 1'b0;
        tick();
        check_eq("d3_flush2_cnt", b3.squash_cnt, 2);
        b3.flush = 1'b0;
        drive3(NOPW);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("d3_post_flush", o3, NOPW);
        end

        // DEPTH=4, CNT_W=3 saturation: 4, then 6, then 7, then stays 7
        for (int i = 0; i < 4; i++) begin
            drive4(W1); tick();
        end
        check_eq("d4_lat", o4, W1);
        b4.flush = 1'b1; tick(); b4.flush = 1'b0;
        check_eq("d4_cnt4", b4.squash_cnt, 4);
        for (int i = 0; i < 2; i++) begin
            drive4(W2); tick();
        end
        b4.flush = 1'b1; tick(); b4.flush = 1'b0;
        check_eq("d4_cnt6", b4.squash_cnt, 6);
        for (int i = 0; i < 4; i++) begin
            drive4(W3); tick();
        end
        b4.flush = 1'b1; tick(); b4.flush = 1'b0;
        check_eq("d4_sat7", b4.squash_cnt, 7);
        check_eq("d4_sat_out", o4, NOPW);
        drive4(W1); tick();
        b4.flush = 1'b1; tick(); b4.flush = 1'b0;
        check_eq("d4_hold7", b4.squash_cnt, 7);
        drive4(NOPW);

        // Reset with live stages and flush asserted, then restart
        drive3(W1); tick();
        drive3(W2); tick();
        b3.flush = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b3.flush = 1'b0;
        check_eq("rst_mid_out", o3, NOPW);
        check_eq("rst_mid_cnt3", b3.squash_cnt, 0);
        check_eq("rst_mid_cnt4", b4.squash_cnt, 0);
        drive3(W3); tick();
        drive3(NOPW);
        check_eq("restart_e1", o3, NOPW);
        tick(); check_eq("restart_e2", o3, NOPW);
        tick(); check_eq("restart_e3", o3, W3);
        tick(); check_eq("restart_e4", o3, NOPW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
